// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and constants for the BTB update controller
package btb_pkg;

    localparam int BTB_ENTRIES = 256;
    localparam int IDX_W       = $clog2(BTB_ENTRIES);

    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(BTB_ENTRIES - 1);

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] target;
        logic        taken;
    } btb_update_t;

    typedef enum logic {
        INIT,
        RUN
    } btb_ctrl_state_t;

endpackage

// File: rtl/btb_update_fifo.sv
// rtl/btb_update_fifo.sv - in-order update queue, two write ports and one read port
module btb_update_fifo
    import btb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_en0,
    input  btb_update_t   wr_data0,
    input  logic          wr_en1,
    input  btb_update_t   wr_data1,
    input  logic          rd_en,
    output btb_update_t   rd_data,
    output logic [CW-1:0] count
);

    btb_update_t   mem_q [DEPTH];
    btb_update_t   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Port 0 is older, so it takes the lower slot when both write.
            if (wr_en0) begin
                mem_d[wr_ptr_q] = wr_data0;
            end
            if (wr_en1) begin
                mem_d[wr_en0 ? wr_ptr_q + PW'(1) : wr_ptr_q] = wr_data1;
            end
            wr_ptr_d = wr_ptr_q + PW'(wr_en0) + PW'(wr_en1);
            rd_ptr_d = rd_ptr_q + PW'(rd_en);
            count_d  = count_q + CW'(wr_en0) + CW'(wr_en1) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write sequencer: valid-bit sweep, then queued resolve updates
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int B_WIDTH = 7,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flush,
    input  logic             resValid0,
    input  logic             resValid1,
    input  logic [B_WIDTH:0] resPC0,
    input  logic [B_WIDTH:0] resPC1,
    input  logic [WIDTH:0]   resTarget0,
    input  logic [WIDTH:0]   resTarget1,
    input  logic             resTaken0,
    input  logic             resTaken1,
    output logic             resolveReady,
    output logic             branch,
    output logic             wasTakenBranch,
    output logic [B_WIDTH:0] oldPC,
    output logic [WIDTH:0]   resolvedTarget,
    output logic             btbReady
);

    localparam int CW = $clog2(DEPTH) + 1;

    btb_ctrl_state_t  state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic             branch_q, branch_d;
    logic             was_taken_q, was_taken_d;
    logic [B_WIDTH:0] old_pc_q, old_pc_d;
    logic [WIDTH:0]   target_q, target_d;
    logic             resolve_ready_q, resolve_ready_d;
    logic             btb_ready_q, btb_ready_d;

    logic             push0, push1, pop, fifo_clear;
    logic [CW-1:0]    fifo_count, count_next;
    btb_update_t      upd0, upd1, head;

    assign upd0 = '{pc: resPC0, target: resTarget0, taken: resTaken0};
    assign upd1 = '{pc: resPC1, target: resTarget1, taken: resTaken1};

    btb_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (resetN),
        .clear    (fifo_clear),
        .wr_en0   (push0),
        .wr_data0 (upd0),
        .wr_en1   (push1),
        .wr_data1 (upd1),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        branch_d    = 1'b0;
        was_taken_d = 1'b0;
        old_pc_d    = old_pc_q;
        target_d    = target_q;
        push0       = 1'b0;
        push1       = 1'b0;
        pop         = 1'b0;
        fifo_clear  = 1'b0;

        if (flush) begin
            // Everything in flight is discarded, including this cycle's output.
            state_d     = INIT;
            sweep_idx_d = '0;
            fifo_clear  = 1'b1;
        end else if (state_q == INIT) begin
            branch_d    = 1'b1;
            old_pc_d    = (B_WIDTH+1)'(sweep_idx_q);
            target_d    = '0;
            sweep_idx_d = sweep_idx_q + IDX_W'(1);
            if (sweep_idx_q == SWEEP_LAST) begin
                state_d = RUN;
            end
        end else begin
            push0 = resValid0 && resolve_ready_q;
            push1 = resValid1 && resolve_ready_q;
            if (fifo_count != '0) begin
                pop         = 1'b1;
                branch_d    = 1'b1;
                was_taken_d = head.taken;
                old_pc_d    = head.pc;
                target_d    = head.target;
            end
        end

        // Ready is registered, so it must already reserve room for a dual push next cycle.
        count_next      = fifo_clear ? '0
                        : fifo_count + CW'(push0) + CW'(push1) - CW'(pop);
        resolve_ready_d = (state_d == RUN) && (count_next <= CW'(DEPTH - 2));
        btb_ready_d     = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= INIT;
            sweep_idx_q     <= '0;
            branch_q        <= 1'b0;
            was_taken_q     <= 1'b0;
            old_pc_q        <= '0;
            target_q        <= '0;
            resolve_ready_q <= 1'b0;
            btb_ready_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sweep_idx_q     <= sweep_idx_d;
            branch_q        <= branch_d;
            was_taken_q     <= was_taken_d;
            old_pc_q        <= old_pc_d;
            target_q        <= target_d;
            resolve_ready_q <= resolve_ready_d;
            btb_ready_q     <= btb_ready_d;
        end
    end

    assign branch         = branch_q;
    assign wasTakenBranch = was_taken_q;
    assign oldPC          = old_pc_q;
    assign resolvedTarget = target_q;
    assign resolveReady   = resolve_ready_q;
    assign btbReady       = btb_ready_q;

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Sequences all writes into the branch target buffer. It clears every valid bit after reset or flush with a 256-cycle sweep. It then merges branch-resolution results from two execute-side branch units into a small in-order update queue and drains that queue into the BTB write port at one update per cycle. Fetch uses `btbReady` to ignore BTB predictions while the table is being swept.

## Interface
- WIDTH, 31, MSB of instruction/target address (32-bit)
- B_WIDTH, 7, MSB of BTB index (256 entries)
- DEPTH, 4, update queue entries (power of two, ≥4)
- clk  in  1  clock, all state on posedge
- resetN  in  1  reset, asynchronous, active-low
- flush  in  1  invalidate whole BTB (context switch / self-modifying code)
- resValid0, resValid1  in  1  branch resolved on port 0 / port 1 this cycle
- resPC0, resPC1  in  B_WIDTH+1  BTB index of the resolved branch
- resTarget0, resTarget1  in  WIDTH+1  resolved target address
- resTaken0, resTaken1  in  1  branch was taken
- resolveReady  out  1  both ports may present a result this cycle
- branch  out  1  BTB valid-buffer write enable
- wasTakenBranch  out  1  BTB target write enable and valid bit value
- oldPC  out  B_WIDTH+1  BTB write index
- resolvedTarget  out  WIDTH+1  BTB write data
- btbReady  out  1  BTB contents are valid for prediction

## Operation
- States: INIT (sweep) and RUN.
- Reset drives INIT, sweep index 0, queue empty, and every output 0.
- INIT: each cycle outputs branch=1, wasTakenBranch=0, oldPC=index, resolvedTarget=0, then increments the index. After index 255 is issued, the next state is RUN. The queue accepts nothing. resolveReady=0 and btbReady=0.
- RUN: btbReady=1.
- Push: resValid0 pushes first, resValid1 pushes second, so port 0 is treated as older. Zero, one or two pushes happen per cycle.
- Pop: if the queue is non-empty, the head is registered onto the outputs as branch=1, wasTakenBranch=taken, oldPC, resolvedTarget. Otherwise branch=0 and wasTakenBranch=0, and oldPC/resolvedTarget hold their previous values.
- Not-taken entries still emit branch=1 so that the valid bit is cleared.
- resolveReady=1 only in RUN with count ≤ DEPTH−2.
  - Pushes with resolveReady=0 are dropped.
  - Such pushes are a protocol violation and are flagged by a bench assertion.
- flush, whether in INIT or RUN:
  - Next cycle: queue empty, state INIT, index 0.
  - Resolves presented in the flush cycle are dropped.
  - The output for the flush cycle itself is suppressed (branch=0).
- Same-index updates are written in queue order. The last write wins.

## Timing
- All outputs are registered.
- A result accepted at edge N, with the queue empty beforehand, appears on the outputs after edge N+1, and the BTB writes at edge N+2. There is no same-cycle push-to-pop bypass.
- Throughput is one update per cycle. Queue count changes by −1 to +2 per cycle, and count width is clog2(DEPTH)+1.
- Full sweep duration: 256 cycles of branch=1. btbReady rises on the first RUN cycle, 257 cycles after reset release.
- The sweep index is 8 bits and wraps only via the INIT→RUN transition.
- resetN asserted mid-operation: outputs go to 0 immediately (asynchronous), queue contents are lost, and the sweep restarts at 0 after deassertion.
- Flush and reset in the same cycle: reset wins.

## Structure
- btb_pkg holds:
  - btb_update_t {logic[7:0] pc; logic[31:0] target; logic taken}
  - BTB_ENTRIES=256
  - typedef enum {INIT, RUN} btb_ctrl_state_t
- Sub-module btb_update_fifo: DEPTH-entry circular buffer with 2 write ports and 1 read port.
  - Pointers wrap modulo DEPTH.
  - Ports: count out, clear in.
  - Instantiated once.
- The top level holds the FSM, sweep counter and output register.

## Test plan
- Reset release, idle ports → 256 consecutive cycles with branch=1, wasTakenBranch=0, oldPC=0x00..0xFF; then btbReady=1 and resolveReady=1.
- RUN, port 0 pc=0x12 target=0x0000_0400 taken → exactly one cycle later branch=1, wasTakenBranch=1, oldPC=0x12, resolvedTarget=0x400, followed by branch=0.
- Same cycle, port 0 pc=0x10 taken target=0x800 and port 1 pc=0x20 not taken → outputs 0x10 (taken) then 0x20 (wasTakenBranch=0, branch=1) on consecutive cycles.
- Dual resolves on every cycle where resolveReady=1, for 10 cycles → resolveReady deasserts when count reaches 3, no accepted update is lost, and output order equals acceptance order.
- Queue holds 3 entries, flush asserted together with a port 0 resolve → none of the queued or new updates are emitted, and the sweep restarts at oldPC=0x00.
- resetN pulsed low when the sweep is at index 0x80 → outputs are 0 during reset, the sweep restarts at 0x00 after release, and btbReady stays 0 until 256 sweep cycles complete.
